ram_fifo_sdpram: RTL and testbench

//  Simple dual-port block RAM (one write port, one read port) used as the storage

---
 rtl/ram_fifo_sdpram.sv | 72 +++++++
 tb/tb_ram_fifo_sdpram.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_sdpram.sv
// Simple dual-port RAM: one write port, one read port, single clock, registered read
// with an optional second output stage. Read-first on same-address collisions.
module ram_fifo_sdpram #(
  parameter  int ADDR_WIDTH = 11,
  parameter  int DATA_WIDTH = 16,
  parameter  int OUTPUT_REG = 0,
  parameter  int RD_OCE_EN  = 0,
  parameter  int WR_BYTE_EN = 0,
  parameter  int BYTE_SIZE  = 8,
  localparam int BE_WIDTH   = (DATA_WIDTH + BYTE_SIZE - 1) / BYTE_SIZE,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_oce,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [BE_WIDTH-1:0]   be_eff;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  oce_eff;
  logic [DATA_WIDTH-1:0] rd_q1_d, rd_q1_q;
  logic [DATA_WIDTH-1:0] rd_q2_d, rd_q2_q;

  // Expand byte-lane enables to a per-bit mask; the top lane may be partial.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_mask = '0;
    be_eff  = (WR_BYTE_EN != 0) ? wr_byte_en : '1;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      wr_mask[b] = be_eff[b / BYTE_SIZE];
    end
  end

  // NOTE: the storage array has no reset; clearing it would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (wr_mask[b]) begin
          mem[wr_addr][b] <= wr_data[b];
        end
      end
    end
  end

  always_comb begin
    oce_eff = (RD_OCE_EN == 0) || rd_oce;
    rd_q1_d = rst ? '0 : mem[rd_addr];
    rd_q2_d = rd_q2_q;
    if (rst) begin
      rd_q2_d = '0;
    end else if (oce_eff) begin
      rd_q2_d = rd_q1_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    rd_q1_q <= rd_q1_d;
    rd_q2_q <= rd_q2_d;
  end

  assign rd_data = (OUTPUT_REG != 0) ? rd_q2_q : rd_q1_q;

endmodule

// File: tb/tb_ram_fifo_sdpram.sv
// Directed bench for ram_fifo_sdpram: a default instance plus one with the output
// register, output clock enable and byte enables turned on.
module tb_ram_fifo_sdpram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance: 2048 x 16, latency 1, no byte enables
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_byte_en = 2'b00;
  logic [10:0] rd_addr = '0;
  logic        rd_oce = 1'b0;
  logic [15:0] rd_data;

  // featured instance: 512 x 16, latency 2, rd_oce and byte enables live
  logic        r_wr_en = 1'b0;
  logic [8:0]  r_wr_addr = '0;
  logic [15:0] r_wr_data = '0;
  logic [1:0]  r_wr_byte_en = 2'b11;
  logic [8:0]  r_rd_addr = '0;
  logic        r_rd_oce = 1'b1;
  logic [15:0] r_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  ram_fifo_sdpram dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_addr(rd_addr), .rd_oce(rd_oce), .rd_data(rd_data)
  );

  ram_fifo_sdpram #(
    .ADDR_WIDTH(9), .DATA_WIDTH(16), .OUTPUT_REG(1), .RD_OCE_EN(1), .WR_BYTE_EN(1)
  ) dut_r (
    .clk(clk), .rst(rst), .wr_en(r_wr_en), .wr_addr(r_wr_addr), .wr_data(r_wr_data),
    .wr_byte_en(r_wr_byte_en), .rd_addr(r_rd_addr), .rd_oce(r_rd_oce), .rd_data(r_rd_data)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fill_val(input int a);
    if (a == 0) return 16'hF800;
    return 16'hFFFF - 16'(a - 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_addr   = 11'(i * 37);
      r_rd_addr = 9'(i * 11);
      tick();
      n_cmp++;
      if (rd_data !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_dflt cycle %0d: got %h want 0000", i, rd_data);
      end
      n_cmp++;
      if (r_rd_data !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_oreg cycle %0d: got %h want 0000", i, r_rd_data);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      wr_addr = 11'((i + 1) % 2048);
      wr_data = 16'hFFFF - 16'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_addr = 11'd1;
    for (int i = 0; i < 2048; i++) begin
      int a;
      a = (i + 1) % 2048;
      tick();
      n_cmp++;
      if (rd_data !== fill_val(a)) begin
        n_err++;
        $display("FAIL fill addr %0d: got %h want %h", a, rd_data, fill_val(a));
      end
      rd_addr = 11'((i + 2) % 2048);
    end
  endtask

  task automatic test_read_during_write();
    wr_en = 1'b1; wr_addr = 11'd5; wr_data = 16'h1234;
    tick();
    wr_data = 16'hABCD; rd_addr = 11'd5;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if (rd_data !== 16'h1234) begin
      n_err++;
      $display("FAIL rdw_old: got %h want 1234", rd_data);
    end
    tick();
    n_cmp++;
    if (rd_data !== 16'hABCD) begin
      n_err++;
      $display("FAIL rdw_new: got %h want abcd", rd_data);
    end
  endtask

  task automatic test_output_reg_oce();
    r_wr_en = 1'b1; r_wr_byte_en = 2'b11;
    r_wr_addr = 9'd1; r_wr_data = 16'hFFFF;
    tick();
    r_wr_addr = 9'd2; r_wr_data = 16'h0002;
    tick();
    r_wr_en = 1'b0;
    r_rd_oce = 1'b1; r_rd_addr = 9'd2;
    tick();
    tick();
    n_cmp++;
    if (r_rd_data !== 16'h0002) begin
      n_err++;
      $display("FAIL oreg_prime: got %h want 0002", r_rd_data);
    end
    // gated: the new word reaches stage 1 but the output must hold
    r_rd_oce = 1'b0; r_rd_addr = 9'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (r_rd_data !== 16'h0002) begin
        n_err++;
        $display("FAIL oreg_hold cycle %0d: got %h want 0002", i, r_rd_data);
      end
    end
    r_rd_oce = 1'b1; r_rd_addr = 9'd2;
    tick();
    tick();
    r_rd_addr = 9'd1;
    tick();
    n_cmp++;
    if (r_rd_data !== 16'h0002) begin
      n_err++;
      $display("FAIL oreg_lat1: got %h want 0002", r_rd_data);
    end
    tick();
    n_cmp++;
    if (r_rd_data !== 16'hFFFF) begin
      n_err++;
      $display("FAIL oreg_lat2: got %h want ffff", r_rd_data);
    end
  endtask

  task automatic test_byte_enable();
    r_wr_en = 1'b1; r_wr_addr = 9'd7;
    r_wr_byte_en = 2'b11; r_wr_data = 16'h0000;
    tick();
    r_wr_byte_en = 2'b01; r_wr_data = 16'hA5C3;
    tick();
    r_wr_en = 1'b0; r_rd_oce = 1'b1; r_rd_addr = 9'd7;
    tick();
    tick();
    n_cmp++;
    if (r_rd_data !== 16'h00C3) begin
      n_err++;
      $display("FAIL be_low: got %h want 00c3", r_rd_data);
    end
    r_wr_en = 1'b1; r_wr_byte_en = 2'b10; r_wr_data = 16'h5A3C;
    tick();
    r_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (r_rd_data !== 16'h5AC3) begin
      n_err++;
      $display("FAIL be_high: got %h want 5ac3", r_rd_data);
    end
  endtask

  task automatic test_mid_reset();
    rd_addr = 11'd10;
    tick();
    n_cmp++;
    if (rd_data !== fill_val(10)) begin
      n_err++;
      $display("FAIL mid_pre: got %h want %h", rd_data, fill_val(10));
    end
    // reset pulse with a write on the same edge: output clears, write lands
    rd_addr = 11'd12; rst = 1'b1;
    wr_en = 1'b1; wr_addr = 11'd20; wr_data = 16'h5555;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (rd_data !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_rst: got %h want 0000", rd_data);
    end
    tick();
    n_cmp++;
    if (rd_data !== fill_val(12)) begin
      n_err++;
      $display("FAIL mid_post12: got %h want %h", rd_data, fill_val(12));
    end
    rd_addr = 11'd5;
    tick();
    n_cmp++;
    if (rd_data !== 16'hABCD) begin
      n_err++;
      $display("FAIL mid_post5: got %h want abcd", rd_data);
    end
    rd_addr = 11'd20;
    tick();
    n_cmp++;
    if (rd_data !== 16'h5555) begin
      n_err++;
      $display("FAIL mid_wr_in_rst: got %h want 5555", rd_data);
    end
    rd_addr = 11'd0;
    tick();
    n_cmp++;
    if (rd_data !== 16'hF800) begin
      n_err++;
      $display("FAIL mid_post0: got %h want f800", rd_data);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill();
    test_read_during_write();
    test_output_reg_oce();
    test_byte_enable();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
